// File: rtl/ddr_cmd_sched.sv
// ddr_cmd_sched: single-bank-at-a-time SDRAM command scheduler with periodic refresh
module ddr_cmd_sched #(
  parameter int T_RCD  = 3,
  parameter int T_WR   = 3,
  parameter int T_RTP  = 2,
  parameter int T_RP   = 3,
  parameter int T_RFC  = 10,
  parameter int T_REFI = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wr,
  input  logic [1:0]  i_req_bank,
  input  logic [12:0] i_req_row,
  input  logic [9:0]  i_req_col,
  input  logic [15:0] i_req_data,
  output logic        o_done,
  output logic        o_cke,
  output logic        o_ras,
  output logic        o_cas,
  output logic        o_we,
  output logic [1:0]  o_ba,
  output logic [12:0] o_addr,
  output logic [15:0] o_data
);
  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_WAIT_RCD, S_RDWR, S_WAIT_PRE, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC
  } state_t;
  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [2:0]  r_cmd;
  logic [15:0] r_ref_cnt;
  logic        r_ref_pend;
  logic        r_wr;
  logic [9:0]  r_col;
  logic [15:0] r_wdata;
  logic        w_wrap;
  logic        w_issue;
  logic        w_pend_nxt;
  assign {o_ras, o_cas, o_we} = r_cmd;
  assign w_wrap     = r_ref_cnt == 16'(T_REFI - 1);
  assign w_issue    = r_state == S_IDLE && r_ref_pend;
  assign w_pend_nxt = w_wrap || (r_ref_pend && !w_issue);
  // Free-running refresh interval counter; a wrap leaves at most one refresh pending
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else begin
      r_ref_cnt  <= w_wrap ? '0 : r_ref_cnt + 16'd1;
      r_ref_pend <= w_pend_nxt;
    end
  end
  // Command FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd       <= C_NOP;
      r_wr        <= 1'b0;
      r_col       <= '0;
      r_wdata     <= '0;
      o_req_ready <= 1'b0;
      o_done      <= 1'b0;
      o_cke       <= 1'b0;
      o_ba        <= '0;
      o_addr      <= '0;
      o_data      <= '0;
    end else begin
      o_cke       <= 1'b1;
      r_cmd       <= C_NOP;
      o_done      <= 1'b0;
      o_req_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_ref_pend) begin
            r_state <= S_REF;
            r_cmd   <= C_REF;
            o_ba    <= '0;
            o_addr  <= '0;
            r_cnt   <= 4'(T_RFC - 1);
          end else if (i_req_valid && o_req_ready) begin
            r_state <= S_ACT;
            r_cmd   <= C_ACT;
            r_wr    <= i_req_wr;
            r_col   <= i_req_col;
            r_wdata <= i_req_data;
            o_ba    <= i_req_bank;
            o_addr  <= i_req_row;
            r_cnt   <= 4'(T_RCD - 1);
          end else begin
            o_req_ready <= !w_pend_nxt;
          end
        end
        S_ACT, S_WAIT_RCD: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RDWR;
            r_cmd   <= r_wr ? C_WR : C_RD;
            o_addr  <= {3'b000, r_col};
            o_data  <= r_wr ? r_wdata : o_data;
            r_cnt   <= 4'(r_wr ? T_WR - 1 : T_RTP - 1);
          end else begin
            r_state <= S_WAIT_RCD;
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        S_RDWR, S_WAIT_PRE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_PRE;
            r_cmd   <= C_PRE;
            o_addr  <= 13'h0400;
            o_done  <= 1'b1;
            r_cnt   <= 4'(T_RP - 1);
          end else begin
            r_state <= S_WAIT_PRE;
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        S_PRE, S_WAIT_RP: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_IDLE;
            o_req_ready <= !w_pend_nxt;
          end else begin
            r_state <= S_WAIT_RP;
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        S_REF: r_state <= S_WAIT_RFC;
        S_WAIT_RFC: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_IDLE;
            o_req_ready <= !w_pend_nxt;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_cmd_sched.sv
// tb_ddr_cmd_sched: scoreboard bench for the SDRAM command scheduler
module tb_ddr_cmd_sched;
  localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100, PRE = 3'b010, REF = 3'b001;
  typedef struct packed {
    logic [31:0] c;
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] data;
    logic        done;
  } ev_t;
  logic clk = 0, rst = 1, req_valid = 0, req_wr = 0;
  logic [1:0] req_bank = 0;
  logic [12:0] req_row = 0;
  logic [9:0] req_col = 0;
  logic [15:0] req_data = 0;
  logic req_ready, done, cke, ras, cas, we;
  logic [1:0] ba;
  logic [12:0] addr;
  logic [15:0] data;
  int cyc = 0, checks = 0, failures = 0;
  ev_t exp_q[$];
  ev_t act_ev, exp_ev;

  ddr_cmd_sched dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_wr(req_wr), .i_req_bank(req_bank), .i_req_row(req_row), .i_req_col(req_col),
    .i_req_data(req_data), .o_done(done), .o_cke(cke), .o_ras(ras), .o_cas(cas), .o_we(we),
    .o_ba(ba), .o_addr(addr), .o_data(data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always @(negedge clk) begin
    if ({ras, cas, we} != NOP || done) begin
      act_ev = {32'(cyc), {ras, cas, we}, ba, addr, data, done};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_cmd cyc=%0d cmd=%b ba=%0d addr=%h data=%h done=%b", cyc, {ras, cas, we}, ba, addr, data, done);
      end else begin
        exp_ev = exp_q.pop_front();
        if (act_ev !== exp_ev)
          begin
            failures++;
            $display("FAIL cmd_event got cyc=%0d cmd=%b ba=%0d addr=%h data=%h done=%b, expected cyc=%0d cmd=%b ba=%0d addr=%h data=%h done=%b",
                     act_ev.c, act_ev.cmd, act_ev.ba, act_ev.addr, act_ev.data, act_ev.done,
                     exp_ev.c, exp_ev.cmd, exp_ev.ba, exp_ev.addr, exp_ev.data, exp_ev.done);
          end
      end
    end
  end

  task automatic push(input int c, input logic [2:0] cmd, input logic [1:0] b, input logic [12:0] a,
                      input logic [15:0] d, input logic dn);
    ev_t e;
    e = {32'(c), cmd, b, a, d, dn};
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [1:0] b, input logic [12:0] r, input logic [9:0] cl, input logic [15:0] d);
    req_valid = 1; req_wr = w; req_bank = b; req_row = r; req_col = cl; req_data = d;
  endtask

  task automatic check_reset_outputs();
    check("rst_cke", 32'(cke), 0);
    check("rst_cmd", 32'({ras, cas, we}), 32'(NOP));
    check("rst_bus", {ba, addr, data}, 0);
    check("rst_ready_done", 32'({req_ready, done}), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 0;
    at(1);
    check("cke_after_rst", 32'(cke), 1);
    check("ready_after_rst", 32'(req_ready), 1);
    // write: bank 1, row 0x0123, col 0x045, data 0xBEEF
    at(10);
    drive(1, 2'd1, 13'h0123, 10'h045, 16'hBEEF);
    push(11, ACT, 2'd1, 13'h0123, 16'h0000, 0);
    push(14, WR,  2'd1, 13'h0045, 16'hBEEF, 0);
    push(17, PRE, 2'd1, 13'h0400, 16'hBEEF, 1);
    at(11); req_valid = 0; check("ready_busy_wr", 32'(req_ready), 0);
    at(19); check("ready_before_wr_rp", 32'(req_ready), 0);
    at(20); check("ready_after_wr", 32'(req_ready), 1);
    // read: DATA must keep 0xBEEF
    drive(0, 2'd2, 13'h1ABC, 10'h3FF, 16'hDEAD);
    push(21, ACT, 2'd2, 13'h1ABC, 16'hBEEF, 0);
    push(24, RD,  2'd2, 13'h03FF, 16'hBEEF, 0);
    push(26, PRE, 2'd2, 13'h0400, 16'hBEEF, 1);
    at(21); req_valid = 0;
    at(28); check("ready_before_rd_rp", 32'(req_ready), 0);
    at(29); check("ready_after_rd", 32'(req_ready), 1);
    // first refresh expiry
    push(65, REF, 2'd0, 13'h0000, 16'hBEEF, 0);
    at(63); check("ready_pre_refresh", 32'(req_ready), 1);
    at(64); check("ready_ref_pend", 32'(req_ready), 0);
    at(75); check("ready_in_rfc", 32'(req_ready), 0);
    at(76); check("ready_after_rfc", 32'(req_ready), 1);
    // write straddling the second expiry, with a read queued behind it
    at(124);
    drive(1, 2'd0, 13'h0007, 10'h201, 16'h1234);
    push(125, ACT, 2'd0, 13'h0007, 16'hBEEF, 0);
    push(128, WR,  2'd0, 13'h0201, 16'h1234, 0);
    push(131, PRE, 2'd0, 13'h0400, 16'h1234, 1);
    push(135, REF, 2'd0, 13'h0000, 16'h1234, 0);
    push(147, ACT, 2'd3, 13'h1FFF, 16'h1234, 0);
    push(150, RD,  2'd3, 13'h0000, 16'h1234, 0);
    push(152, PRE, 2'd3, 13'h0400, 16'h1234, 1);
    at(125); drive(0, 2'd3, 13'h1FFF, 10'h000, 16'h5555);
    at(134); check("ready_idle_ref_wins", 32'(req_ready), 0);
    at(146); check("ready_after_queued_ref", 32'(req_ready), 1);
    at(147); req_valid = 0; check("ready_busy_queued", 32'(req_ready), 0);
    at(155); check("ready_after_queued", 32'(req_ready), 1);
    // reset during WAIT_RCD aborts the write
    at(160);
    drive(1, 2'd1, 13'h0AAA, 10'h155, 16'hCAFE);
    push(161, ACT, 2'd1, 13'h0AAA, 16'h1234, 0);
    at(161); req_valid = 0;
    at(162); rst = 1;
    @(negedge clk);
    check_reset_outputs();
    rst = 0;
    at(1);
    check("cke_after_abort", 32'(cke), 1);
    check("ready_after_abort", 32'(req_ready), 1);
    at(20);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr_cmd_sched.md
DDR_CMD_SCHED -- requirements
Module: ddr_cmd_sched

Interface
REQ-001 Parameter T_RCD, 3, cycles from ACTIVE to READ/WRITE.
REQ-002 Parameter T_WR, 3, cycles from WRITE to PRECHARGE.
REQ-003 Parameter T_RTP, 2, cycles from READ to PRECHARGE.
REQ-004 Parameter T_RP, 3, cycles from PRECHARGE to next command.
REQ-005 Parameter T_RFC, 10, cycles from REFRESH to next command.
REQ-006 Parameter T_REFI, 64, refresh interval in cycles.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 CLK  in  1  sole clock; all state updates on rising edge.
REQ-009 RST  in  1  synchronous active-high reset.
REQ-010 REQ_VALID  in  1  requester has an access pending.
REQ-011 REQ_READY  out  1  scheduler accepts a request this cycle.
REQ-012 REQ_WR  in  1  1 = write, 0 = read.
REQ-013 REQ_BANK  in  2  target bank.
REQ-014 REQ_ROW  in  13  target row.
REQ-015 REQ_COL  in  10  target column.
REQ-016 REQ_DATA  in  16  write data.
REQ-017 DONE  out  1  one-cycle pulse when an accepted access reaches PRECHARGE.
REQ-018 CKE, RAS, CAS, WE  out  1 each  SDRAM control pins (RAS/CAS/WE active-low).
REQ-019 BA  out  2  bank address.
REQ-020 ADDR  out  13  row/column address; ADDR[10] is the precharge flag.
REQ-021 DATA  out  16  write data.

Function
REQ-022 All outputs SHALL be registered; the command encoding SHALL be {RAS,CAS,WE}: NOP 111, ACTIVE 011, READ 101, WRITE 100, PRECHARGE 010, REFRESH 001.
REQ-023 The FSM SHALL have states IDLE, ACT, WAIT_RCD, RDWR, WAIT_PRE, PRE, WAIT_RP, REF, WAIT_RFC.
REQ-024 REQ_READY SHALL be 1 only in IDLE with no refresh pending; a request is accepted when REQ_VALID and REQ_READY are both 1, and all REQ_* fields SHALL be latched at that edge.
REQ-025 For a request accepted at edge N: ACTIVE (BA=bank, ADDR=row) at N+1; READ/WRITE (ADDR[9:0]=col, ADDR[10]=0, ADDR[12:11]=0) at N+1+T_RCD; PRECHARGE at N+1+T_RCD+T_WR (write) or +T_RTP (read), with ADDR[10]=1; REQ_READY=1 again at PRE+T_RP.
REQ-026 Each command SHALL be driven for exactly one cycle; every other cycle SHALL be NOP.
REQ-027 DATA SHALL carry the latched write data during the WRITE cycle and hold it until the next accepted write; it SHALL not change on reads.
REQ-028 DONE SHALL pulse in the PRECHARGE cycle of an accepted access only.
REQ-029 The refresh counter SHALL count 0..T_REFI-1 every cycle and wrap; at each wrap it SHALL set REF_PEND.
REQ-030 A wrap while REF_PEND is already set SHALL leave one refresh pending (no queueing).
REQ-031 In IDLE with REF_PEND=1: REFRESH (BA=0, ADDR=0) issued next cycle, REF_PEND cleared on issue, then WAIT_RFC for T_RFC cycles, then IDLE.
REQ-032 When REF_PEND and REQ_VALID coincide in IDLE, refresh SHALL win and REQ_READY SHALL be 0.
REQ-033 An in-progress access SHALL never be interrupted by refresh expiry; REF_PEND is serviced on return to IDLE.
REQ-034 Wait counters SHALL support timing parameters of 1..15; a value of 1 means the next command follows in the immediately next cycle.

Reset
REQ-035 While RST=1: CKE=0, RAS=CAS=WE=1, BA=0, ADDR=0, DATA=0, REQ_READY=0, DONE=0, FSM=IDLE, refresh counter=0, REF_PEND=0.
REQ-036 The first cycle after RST deasserts SHALL drive CKE=1 and REQ_READY=1.
REQ-037 RST asserted mid-access SHALL abort the sequence immediately with no further command issued.

Verification
REQ-038 Write accepted at cycle 10 (bank 1, row 0x0123, col 0x045, data 0xBEEF) -> ACTIVE at 11, WRITE at 14 with DATA=0xBEEF, PRECHARGE+DONE at 17, REQ_READY=1 at 20.
REQ-039 Read accepted at cycle 10 -> ACTIVE 11, READ 14, PRECHARGE 16, REQ_READY=1 at 19; DATA unchanged.
REQ-040 Idle after reset release at cycle 0 -> REFRESH at cycle 65, REQ_READY=0 cycles 64-75, REQ_READY=1 at 76.
REQ-041 REQ_VALID held high across refresh expiry during a write -> write completes, REFRESH issued next cycle after return to IDLE, then queued request accepted.
REQ-042 RST asserted in WAIT_RCD -> next cycle all outputs at reset values, no READ/WRITE issued.
